complex_real_divider: RTL
=========================

// Module: complex_real_divider
// PURPOSE
//   Sequential fixed-point divider that divides a packed complex sample {imag,real} by a signed real divisor.
//   Returns packed complex quotient {imag,real} in same format.
//   Sits downstream of the conjugate/multiply stages in the MOSSE filter update: computes H* = A / B.
//     A = G*conj(F), complex numerator; B = F*conj(F) + eps, real denominator.
//   Valid/ready streaming on both sides; one division in flight.
// PARAMETERS
//   WIDTH  32  bit width of each real/imag component and of the divisor (two's complement)
//   FRAC   16  fractional bits of quotient: q = (num << FRAC) / den
// PORTS
//   clk              in   1        single clock, all logic on rising edge
//   rst              in   1        synchronous, active-high reset
//   in_valid         in   1        input operands valid
//   in_ready         out  1        block can accept operands
//   in_num           in   2*WIDTH  numerator {imag[2W-1:W], real[W-1:0]}, signed
//   in_den           in   WIDTH    divisor, signed real
//   out_valid        out  1        quotient valid, held until accepted
//   out_ready        in   1        downstream accepts quotient
//   out_quot         out  2*WIDTH  quotient {imag,real}, signed, FRAC fractional bits
//   out_div_by_zero  out  1        qualifies out_quot: divisor was 0
// BEHAVIOUR
//   Clocking/reset: one clock (clk); reset rst is synchronous, active-high.
//   Reset: state=IDLE, in_ready=1, out_valid=0, out_quot=0, out_div_by_zero=0, counter=0.
//     Reset wins over all other events, including mid-division and output held with out_ready=0.
//     Any in-flight operation is discarded; no output is produced for it.
//   FSM IDLE -> DIV -> FIX -> DONE -> IDLE.
//     IDLE: in_ready=1. On in_valid&&in_ready, register operands.
//       Latch sign_re, sign_im, sign_den and magnitudes; magnitudes are WIDTH+1 bits so -2^(W-1) is exact.
//       Go to DIV with cnt=0.
//     DIV: two parallel unsigned restoring dividers (real, imag) share one counter.
//       Dividend magnitude is |num| << FRAC, WIDTH+FRAC+1 bits.
//       One quotient bit per cycle, MSB first; N = WIDTH+FRAC iterations; leaves when cnt==N-1.
//     FIX: apply sign (quotient negative iff sign_num XOR sign_den), saturate, register out_quot.
//       Next state DONE.
//     DONE: out_valid=1. Leave to IDLE on out_ready.
//       out_quot and out_div_by_zero stay stable while out_valid&&!out_ready.
//   in_ready=0 in DIV/FIX/DONE: no overlap, no skid buffer.
//     A new operand is accepted the cycle after the output handshake, never the same cycle.
//   Latency: operands accepted at edge k -> out_valid high after edge k+N+2.
//     Fixed, independent of data, including the divide-by-zero case.
//   Rounding: truncation toward zero on magnitude, then sign applied (e.g. -0.33 -> 0).
//   Saturation per component: positive result > 2^(W-1)-1 -> 2^(W-1)-1; negative result < -2^(W-1) -> -2^(W-1).
//   den==0: out_div_by_zero=1.
//     Each component = +max if num>0, -2^(W-1) if num<0, 0 if num==0.
//     Divider datapath still runs; result overridden in FIX.
//   out_div_by_zero is cleared when the next operation is accepted.
//   in_num/in_den are ignored outside the IDLE handshake cycle.
// STRUCTURE
//   Shared package mosse_pkg:
//     complex pack/unpack functions ({imag,real} layout);
//     signed saturation function sat_w;
//     FSM state typedef (IDLE/DIV/FIX/DONE).
//   One sub-module udiv_restoring_step, instantiated twice (real, imag):
//     combinational single-iteration compare/subtract/shift;
//     ports: partial remainder, dividend, divisor magnitude; outputs: next remainder, quotient bit.
//   Top level holds FSM, counter, operand/sign registers and output registers.
// TESTING (bench with WIDTH=16, FRAC=8 -> N=24, latency 26)
//   num={0xFE80,0x0300} (-1.5, 3.0), den=0x0200 (2.0)
//     -> out_quot={0xFF40,0x0180} (-0.75, 1.5), flag=0; out_valid exactly 26 cycles after accept.
//   num={0x0000,0x0100}, den=0x0000 -> out_quot={0x0000,0x7FFF}, out_div_by_zero=1, same latency.
//   num={0x8000,0x7FFF}, den=0x0001 -> saturation: out_quot={0x8000,0x7FFF}, flag=0.
//   num={0x0000,0xFFFF}, den=0x0300 -> truncation toward zero: out_quot={0x0000,0x0000}.
//   Backpressure: hold out_ready=0 for 10 cycles.
//     -> out_valid and out_quot stable, in_ready=0 throughout;
//     in_ready=1 the cycle after the out handshake.
//   Reset mid-operation: assert rst at DIV cnt=10.
//     -> next cycle in_ready=1, out_valid=0, out_quot=0;
//     next operation {0,0x0300}/0x0200 returns {0,0x0180}.

Source files
------------

// File: rtl/mosse_pkg.sv
// Shared types and helpers for the MOSSE filter-update datapath.
package mosse_pkg;

  localparam int unsigned MAX_W = 64;          // widest supported component
  localparam int unsigned MAX_Q = 128;         // widest supported quotient magnitude
  localparam int unsigned PK_W  = 2 * MAX_W;   // widest packed complex word

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Mask covering the low w bits of a component.
  function automatic logic [MAX_W-1:0] cplx_mask(input int unsigned w);
    return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

  // Real part of a packed {imag,real} word with w-bit components.
  function automatic logic [MAX_W-1:0] cplx_re(input logic [PK_W-1:0] c, input int unsigned w);
    return c[MAX_W-1:0] & cplx_mask(w);
  endfunction

  // Imaginary part of a packed {imag,real} word with w-bit components.
  function automatic logic [MAX_W-1:0] cplx_im(input logic [PK_W-1:0] c, input int unsigned w);
    return MAX_W'(c >> w) & cplx_mask(w);
  endfunction

  // Pack two w-bit components as {imag,real}.
  function automatic logic [PK_W-1:0] cplx_pack(input logic [MAX_W-1:0] re,
                                                input logic [MAX_W-1:0] im,
                                                input int unsigned w);
    return ({MAX_W'(0), im & cplx_mask(w)} << w) | {MAX_W'(0), re & cplx_mask(w)};
  endfunction

  // Apply sign to an unsigned magnitude and clamp to the signed w-bit range.
  function automatic logic [MAX_W-1:0] sat_w(input logic [MAX_Q-1:0] mag,
                                             input logic neg,
                                             input int unsigned w);
    logic [MAX_Q-1:0] lim;
    lim = MAX_Q'(1) << (w - 1);
    if (neg) begin
      if (mag >= lim) return MAX_W'(lim);
      return MAX_W'(-mag);
    end
    if (mag >= lim) return MAX_W'(lim - MAX_Q'(1));
    return MAX_W'(mag);
  endfunction

endpackage

// File: rtl/udiv_restoring_step.sv
// One iteration of an unsigned restoring divider: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module udiv_restoring_step #(
  parameter int unsigned MAG_W = 33
) (
  input  logic [MAG_W-1:0] i_rem,
  input  logic             i_dvd_bit,
  input  logic [MAG_W-1:0] i_den,
  output logic [MAG_W-1:0] o_rem,
  output logic             o_qbit
);

  logic [MAG_W:0] w_shifted;
  logic [MAG_W:0] w_den_ext;

  assign w_shifted = {i_rem, i_dvd_bit};
  assign w_den_ext = {1'b0, i_den};
  assign o_qbit    = (w_shifted >= w_den_ext);
  assign o_rem     = o_qbit ? MAG_W'(w_shifted - w_den_ext) : MAG_W'(w_shifted);

endmodule

// File: rtl/complex_real_divider.sv
// Sequential fixed-point divide of a packed complex sample by a signed real
// divisor: q = (num << FRAC) / den per component, truncated toward zero,
// saturated to WIDTH bits. One operation in flight at a time.
module complex_real_divider
  import mosse_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0]   in_den,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_quot,
  output logic               out_div_by_zero
);

  localparam int unsigned MAG_W  = WIDTH + 1;
  localparam int unsigned N_ITER = WIDTH + FRAC;
  localparam int unsigned CNT_W  = $clog2(N_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  div_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [MAG_W-1:0]  r_rem_re, r_rem_im, r_den_mag;
  logic [N_ITER-1:0] r_dvd_re, r_dvd_im;
  logic [N_ITER-1:0] r_q_re, r_q_im;
  logic              r_sign_re, r_sign_im, r_sign_den;
  logic              r_zero_re, r_zero_im, r_den_zero;

  logic [WIDTH-1:0]  w_num_re, w_num_im;
  logic [MAG_W-1:0]  w_mag_re, w_mag_im, w_mag_den;
  logic [MAG_W-1:0]  w_rem_re_nxt, w_rem_im_nxt;
  logic              w_qbit_re, w_qbit_im;
  logic [WIDTH-1:0]  w_fix_re, w_fix_im;

  // Magnitude with one extra bit so that -2^(WIDTH-1) stays exact.
  function automatic logic [MAG_W-1:0] mag_of(input logic [WIDTH-1:0] x);
    logic [MAG_W-1:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? (~ext + MAG_W'(1)) : ext;
  endfunction

  // Divide-by-zero result: +max, min or zero following the numerator sign.
  function automatic logic [WIDTH-1:0] dz_val(input logic neg, input logic zero);
    if (zero) return '0;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign w_num_re  = WIDTH'(cplx_re(PK_W'(in_num), WIDTH));
  assign w_num_im  = WIDTH'(cplx_im(PK_W'(in_num), WIDTH));
  assign w_mag_re  = mag_of(w_num_re);
  assign w_mag_im  = mag_of(w_num_im);
  assign w_mag_den = mag_of(in_den);

  udiv_restoring_step #(.MAG_W(MAG_W)) u_step_re (
    .i_rem     (r_rem_re),
    .i_dvd_bit (r_dvd_re[N_ITER-1]),
    .i_den     (r_den_mag),
    .o_rem     (w_rem_re_nxt),
    .o_qbit    (w_qbit_re)
  );

  udiv_restoring_step #(.MAG_W(MAG_W)) u_step_im (
    .i_rem     (r_rem_im),
    .i_dvd_bit (r_dvd_im[N_ITER-1]),
    .i_den     (r_den_mag),
    .o_rem     (w_rem_im_nxt),
    .o_qbit    (w_qbit_im)
  );

  // Sign restore and saturation, or the divide-by-zero override.
  assign w_fix_re = r_den_zero ? dz_val(r_sign_re, r_zero_re)
                               : WIDTH'(sat_w(MAX_Q'(r_q_re), r_sign_re ^ r_sign_den, WIDTH));
  assign w_fix_im = r_den_zero ? dz_val(r_sign_im, r_zero_im)
                               : WIDTH'(sat_w(MAX_Q'(r_q_im), r_sign_im ^ r_sign_den, WIDTH));

  // Control FSM, shared iteration counter, operand/quotient and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_rem_re        <= '0;
      r_rem_im        <= '0;
      r_den_mag       <= '0;
      r_dvd_re        <= '0;
      r_dvd_im        <= '0;
      r_q_re          <= '0;
      r_q_im          <= '0;
      r_sign_re       <= 1'b0;
      r_sign_im       <= 1'b0;
      r_sign_den      <= 1'b0;
      r_zero_re       <= 1'b0;
      r_zero_im       <= 1'b0;
      r_den_zero      <= 1'b0;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      out_quot        <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_sign_re       <= w_num_re[WIDTH-1];
            r_sign_im       <= w_num_im[WIDTH-1];
            r_sign_den      <= in_den[WIDTH-1];
            r_zero_re       <= (w_num_re == '0);
            r_zero_im       <= (w_num_im == '0);
            r_den_zero      <= (in_den == '0);
            r_den_mag       <= w_mag_den;
            r_dvd_re        <= N_ITER'({w_mag_re, {FRAC{1'b0}}});
            r_dvd_im        <= N_ITER'({w_mag_im, {FRAC{1'b0}}});
            r_rem_re        <= '0;
            r_rem_im        <= '0;
            r_q_re          <= '0;
            r_q_im          <= '0;
            r_cnt           <= '0;
            in_ready        <= 1'b0;
            out_div_by_zero <= 1'b0;
            r_state         <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem_re <= w_rem_re_nxt;
          r_rem_im <= w_rem_im_nxt;
          r_q_re   <= {r_q_re[N_ITER-2:0], w_qbit_re};
          r_q_im   <= {r_q_im[N_ITER-2:0], w_qbit_im};
          r_dvd_re <= {r_dvd_re[N_ITER-2:0], 1'b0};
          r_dvd_im <= {r_dvd_im[N_ITER-2:0], 1'b0};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          out_quot        <= (2*WIDTH)'(cplx_pack(MAX_W'(w_fix_re), MAX_W'(w_fix_im), WIDTH));
          out_div_by_zero <= r_den_zero;
          r_state         <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle raises out_valid; afterwards hold until accepted.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
